// File: rtl/memory_arbiter_pkg.sv
// definitions: shared address/data types plus the arbiter's requester and FSM state enums
package definitions;
  typedef logic [31:0] t_address;
  typedef logic [31:0] t_data;
  typedef enum logic [1:0] {REQ_NONE, REQ_INSTRUCTION, REQ_DATA} t_mem_requester;
  typedef enum logic {S_IDLE, S_WAIT} t_arbiter_state;
endpackage

// File: rtl/memory_arbiter_grant.sv
// memory_arbiter_grant: data-priority arbitration with a bounded data streak so fetch cannot starve
//   i_if_req, i_d_req : pending fetch / data requests
//   i_streak          : consecutive data grants while fetch was waiting
//   i_max_streak      : streak length at which a waiting fetch wins
//   o_grant           : requester to accept this cycle
module memory_arbiter_grant
  import definitions::*;
(
  input  logic           i_if_req,
  input  logic           i_d_req,
  input  logic [3:0]     i_streak,
  input  logic [3:0]     i_max_streak,
  output t_mem_requester o_grant
);
  always_comb
    o_grant = (i_d_req && !(i_if_req && i_streak == i_max_streak)) ? REQ_DATA :
              i_if_req ? REQ_INSTRUCTION : REQ_NONE;
endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-port memory between instruction fetch and load/store, one access in flight
//   i_clk, i_rst_n                      : clock, asynchronous active-low reset
//   i_if_req/i_if_address/o_if_ready    : fetch request handshake
//   o_if_rvalid/o_if_rdata              : fetch read response (pulse + held data)
//   i_d_req/i_d_write/i_d_address/i_d_wdata/o_d_ready : data request handshake
//   o_d_rvalid/o_d_rdata                : load read response (pulse + held data)
//   o_mem_*/i_mem_rdata                 : memory port
module memory_arbiter
  import definitions::*;
#(
  parameter int unsigned MEM_LATENCY     = 1,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  input  logic     i_if_req,
  input  t_address i_if_address,
  output logic     o_if_ready,
  output logic     o_if_rvalid,
  output t_data    o_if_rdata,
  input  logic     i_d_req,
  input  logic     i_d_write,
  input  t_address i_d_address,
  input  t_data    i_d_wdata,
  output logic     o_d_ready,
  output logic     o_d_rvalid,
  output t_data    o_d_rdata,
  output logic     o_mem_enable,
  output logic     o_mem_write_enable,
  output t_address o_mem_address,
  output t_data    o_mem_wdata,
  input  t_data    i_mem_rdata
);
  localparam logic [3:0] LATENCY    = 4'(MEM_LATENCY);
  localparam logic [3:0] MAX_STREAK = 4'(MAX_DATA_STREAK);
  t_arbiter_state state, state_next;
  t_mem_requester grant, accept, owner;
  logic [3:0] latency_count, streak;
  logic read_accept, read_done;
  memory_arbiter_grant u_grant (
    .i_if_req     (i_if_req),
    .i_d_req      (i_d_req),
    .i_streak     (streak),
    .i_max_streak (MAX_STREAK),
    .o_grant      (grant)
  );
  // gating with i_rst_n keeps every output low while reset is held
  always_comb begin
    accept      = (state == S_IDLE && i_rst_n) ? grant : REQ_NONE;
    read_accept = accept == REQ_INSTRUCTION || (accept == REQ_DATA && !i_d_write);
    read_done   = state == S_WAIT && latency_count == 4'd1;
    state_next  = read_accept ? S_WAIT : read_done ? S_IDLE : state;
  end
  assign o_if_ready         = accept == REQ_INSTRUCTION;
  assign o_d_ready          = accept == REQ_DATA;
  assign o_mem_enable       = accept != REQ_NONE;
  assign o_mem_write_enable = o_d_ready && i_d_write;
  assign o_mem_address      = o_d_ready ? i_d_address : o_if_ready ? i_if_address : '0;
  assign o_mem_wdata        = o_d_ready ? i_d_wdata : '0;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_next;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      owner         <= REQ_NONE;
      latency_count <= '0;
      streak        <= '0;
      o_if_rvalid   <= 1'b0;
      o_d_rvalid    <= 1'b0;
      o_if_rdata    <= '0;
      o_d_rdata     <= '0;
    end else begin
      o_if_rvalid <= read_done && owner == REQ_INSTRUCTION;
      o_d_rvalid  <= read_done && owner == REQ_DATA;
      if (read_done && owner == REQ_INSTRUCTION) o_if_rdata <= i_mem_rdata;
      if (read_done && owner == REQ_DATA)        o_d_rdata  <= i_mem_rdata;
      if (read_accept) begin
        owner         <= accept;
        latency_count <= LATENCY;
      end else if (state == S_WAIT) latency_count <= latency_count - 4'd1;
      // streak only advances while fetch is actually waiting
      if (state == S_IDLE)
        streak <= (!i_if_req || o_if_ready) ? '0 :
                  (o_d_ready && streak != MAX_STREAK) ? streak + 4'd1 : streak;
    end
  end
endmodule
